// File: rtl/ap_data_cache_ml.sv
// Direct-mapped, write-back data cache between the AP controller and DDR.
// Serves row (RBR) and column (CBC) CAM accesses; supports a full dirty-line FLUSH.
module ap_data_cache_ml #(
  parameter int NUM_LINES      = 4,
  parameter int LINE_DEPTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int ADDR_WIDTH_CAM = 4,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter logic [DDR_ADDR_WIDTH-1:0] DDR_BASE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd,
  input  logic [ADDR_WIDTH_MEM-1:0] cmd_addr,
  input  logic [ADDR_WIDTH_CAM-1:0] cmd_col,
  input  logic [DATA_WIDTH-1:0]     wdata_rbr,
  input  logic [LINE_DEPTH-1:0]     wdata_cbc,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rdata_rbr,
  output logic [LINE_DEPTH-1:0]     rdata_cbc,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
  output logic                      ddr_wr_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
  output logic [DATA_WIDTH-1:0]     ddr_wr_data,
  input  logic                      ddr_wr_ack
);

  localparam int WORD_W = $clog2(LINE_DEPTH);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH_MEM - WORD_W - IDX_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_LINE = IDX_W'(NUM_LINES - 1);

  localparam logic [2:0] C_RBR_LD = 3'd1;
  localparam logic [2:0] C_RBR_ST = 3'd2;
  localparam logic [2:0] C_CBC_LD = 3'd3;
  localparam logic [2:0] C_CBC_ST = 3'd4;
  localparam logic [2:0] C_FLUSH  = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_RESP, S_FLUSH} state_t;

  state_t                            r_state, w_next;
  logic [2:0]                        r_cmd;
  logic [ADDR_WIDTH_MEM-1:0]         r_addr;
  logic [ADDR_WIDTH_CAM-1:0]         r_col;
  logic [DATA_WIDTH-1:0]             r_wd_rbr;
  logic [LINE_DEPTH-1:0]             r_wd_cbc;
  logic [WORD_W-1:0]                 r_cnt;
  logic [IDX_W-1:0]                  r_scan;
  logic [NUM_LINES-1:0]              r_valid, r_dirty;
  logic [NUM_LINES-1:0][TAG_W-1:0]   r_tag;
  logic [DATA_WIDTH-1:0]             r_rdata_rbr;
  logic [LINE_DEPTH-1:0]             r_rdata_cbc;
  logic [LINE_DEPTH-1:0][DATA_WIDTH-1:0] r_mem [NUM_LINES];

  logic [2:0]                        w_cmd;
  logic [ADDR_WIDTH_MEM-1:0]         w_addr;
  logic [ADDR_WIDTH_CAM-1:0]         w_col;
  logic [DATA_WIDTH-1:0]             w_wd_rbr;
  logic [LINE_DEPTH-1:0]             w_wd_cbc;
  logic [WORD_W-1:0]                 w_word;
  logic [IDX_W-1:0]                  w_idx, w_wb_line;
  logic [TAG_W-1:0]                  w_tag;
  logic w_accept, w_is_mem, w_is_store, w_hit;
  logic w_fill_beat, w_fill_last, w_wb_active, w_wb_beat, w_wb_last, w_access, w_mem_we;
  logic [LINE_DEPTH-1:0][DATA_WIDTH-1:0] w_line, w_new;
  logic [LINE_DEPTH-1:0]             w_cbc_vec;

  // In IDLE the live command is used so hits complete in the accept cycle.
  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_cmd      = (r_state == S_IDLE) ? cmd       : r_cmd;
  assign w_addr     = (r_state == S_IDLE) ? cmd_addr  : r_addr;
  assign w_col      = (r_state == S_IDLE) ? cmd_col   : r_col;
  assign w_wd_rbr   = (r_state == S_IDLE) ? wdata_rbr : r_wd_rbr;
  assign w_wd_cbc   = (r_state == S_IDLE) ? wdata_cbc : r_wd_cbc;
  assign w_word     = w_addr[WORD_W-1:0];
  assign w_idx      = w_addr[WORD_W +: IDX_W];
  assign w_tag      = w_addr[ADDR_WIDTH_MEM-1 -: TAG_W];
  assign w_is_mem   = (w_cmd >= C_RBR_LD) && (w_cmd <= C_CBC_ST);
  assign w_is_store = (w_cmd == C_RBR_ST) || (w_cmd == C_CBC_ST);
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_fill_beat = (r_state == S_FILL) && ddr_rd_valid;
  assign w_fill_last = w_fill_beat && (r_cnt == LAST_BEAT);
  assign w_wb_line   = (r_state == S_FLUSH) ? r_scan : w_idx;
  assign w_wb_active = (r_state == S_WB) || ((r_state == S_FLUSH) && r_dirty[r_scan]);
  assign w_wb_beat   = w_wb_active && ddr_wr_ack;
  assign w_wb_last   = w_wb_beat && (r_cnt == LAST_BEAT);
  assign w_access    = (w_accept && w_is_mem && w_hit) || w_fill_last;
  assign w_mem_we    = w_fill_beat || (w_access && w_is_store);

  // The final fill beat is merged before the pending access sees the line.
  always_comb begin
    w_line = r_mem[w_idx];
    if (w_fill_beat) w_line[r_cnt] = ddr_rd_data;
    w_new = w_line;
    if (w_access && (w_cmd == C_RBR_ST)) w_new[w_word] = w_wd_rbr;
    if (w_access && (w_cmd == C_CBC_ST)) begin
      for (int j = 0; j < LINE_DEPTH; j++) w_new[j][w_col] = w_wd_cbc[j];
    end
    for (int j = 0; j < LINE_DEPTH; j++) w_cbc_vec[j] = w_line[j][w_col];
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd == C_FLUSH)                       w_next = S_FLUSH;
          else if (!w_is_mem || w_hit)              w_next = S_RESP;
          else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WB;
          else                                      w_next = S_FILL;
        end
      end
      S_WB:    if (w_wb_last) w_next = S_FILL;
      S_FILL:  if (w_fill_last) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_FLUSH: if ((r_scan == LAST_LINE) && (!r_dirty[r_scan] || w_wb_last)) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd       <= '0;
      r_addr      <= '0;
      r_col       <= '0;
      r_wd_rbr    <= '0;
      r_wd_cbc    <= '0;
      r_cnt       <= '0;
      r_scan      <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_tag       <= '0;
      r_rdata_rbr <= '0;
      r_rdata_cbc <= '0;
    end else begin
      if (w_accept) begin
        r_cmd    <= cmd;
        r_addr   <= cmd_addr;
        r_col    <= cmd_col;
        r_wd_rbr <= wdata_rbr;
        r_wd_cbc <= wdata_cbc;
        r_cnt    <= '0;
        r_scan   <= '0;
      end else begin
        if (w_fill_beat || w_wb_beat) r_cnt <= r_cnt + 1'b1;
        if ((r_state == S_FLUSH) && (!r_dirty[r_scan] || w_wb_last)) r_scan <= r_scan + 1'b1;
      end
      if (w_wb_last) r_dirty[w_wb_line] <= 1'b0;
      if (w_fill_last) begin
        r_valid[w_idx] <= 1'b1;
        r_tag[w_idx]   <= w_tag;
        r_dirty[w_idx] <= w_is_store;
      end else if (w_access && w_is_store) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_access && (w_cmd == C_RBR_LD)) r_rdata_rbr <= w_line[w_word];
      if (w_access && (w_cmd == C_CBC_LD)) r_rdata_cbc <= w_cbc_vec;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rdata_rbr   = r_rdata_rbr;
  assign rdata_cbc   = r_rdata_cbc;
  assign ddr_rd_req  = (r_state == S_FILL);
  assign ddr_rd_addr = ddr_rd_req ?
                       DDR_BASE + DDR_ADDR_WIDTH'({w_tag, w_idx, {WORD_W{1'b0}}}) : '0;
  assign ddr_wr_req  = w_wb_active;
  assign ddr_wr_addr = w_wb_active ?
                       DDR_BASE + DDR_ADDR_WIDTH'({r_tag[w_wb_line], w_wb_line, r_cnt}) : '0;
  assign ddr_wr_data = w_wb_active ? r_mem[w_wb_line][r_cnt] : '0;

endmodule

// File: tb/tb_ap_data_cache_ml.sv
// Self-checking bench for ap_data_cache_ml: an AP-view golden memory plus a
// valid/tag/dirty line model predict load data and every DDR write-back/fill.
module tb_ap_data_cache_ml;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_col;
  logic [15:0] wdata_rbr, wdata_cbc;
  logic        rsp_valid;
  logic [15:0] rdata_rbr, rdata_cbc;
  logic        ddr_rd_req, ddr_rd_valid, ddr_wr_req, ddr_wr_ack;
  logic [27:0] ddr_rd_addr, ddr_wr_addr;
  logic [15:0] ddr_rd_data, ddr_wr_data;

  always #5 clk = ~clk;

  ap_data_cache_ml dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_addr(cmd_addr), .cmd_col(cmd_col), .wdata_rbr(wdata_rbr), .wdata_cbc(wdata_cbc),
    .rsp_valid(rsp_valid), .rdata_rbr(rdata_rbr), .rdata_cbc(rdata_cbc),
    .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr), .ddr_rd_valid(ddr_rd_valid),
    .ddr_rd_data(ddr_rd_data), .ddr_wr_req(ddr_wr_req), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data(ddr_wr_data), .ddr_wr_ack(ddr_wr_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit abort    = 0;

  logic [15:0] gold [256];
  logic [15:0] ddr  [256];
  logic        m_valid [4];
  logic        m_dirty [4];
  logic [9:0]  m_tag   [4];
  logic [15:0] m_rr, m_rc;

  logic [27:0] exp_q [$];
  logic [27:0] wb_addr_log [$];
  logic [15:0] wb_data_log [$];
  int          last_cyc, last_fill_beats;
  logic [27:0] last_rd_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    for (int a = 0; a < 256; a++) gold[a] = ddr[a];
    m_rr = '0;
    m_rc = '0;
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, input logic [3:0] col,
                         input logic [15:0] wd, input logic [15:0] wc);
    logic [1:0]  idx;
    logic [9:0]  tag;
    logic [27:0] ea, fill_base;
    logic [15:0] w;
    bit          is_mem, is_st, hit, exp_fill, bad_fill;
    int          cyc, fill_beats, fill_gap, wb_gap;
    if (abort) return;
    idx = a[5:4];
    tag = a[15:6];
    fill_base = 28'({a[15:4], 4'h0});
    is_mem = (c >= 3'd1) && (c <= 3'd4);
    is_st  = (c == 3'd2) || (c == 3'd4);
    exp_q.delete();
    wb_addr_log.delete();
    wb_data_log.delete();
    hit = 0;
    exp_fill = 0;
    bad_fill = 0;
    if (is_mem) begin
      hit = m_valid[idx] && (m_tag[idx] == tag);
      if (!hit) begin
        exp_fill = 1;
        if (m_valid[idx] && m_dirty[idx])
          for (int i = 0; i < 16; i++) exp_q.push_back(28'({m_tag[idx], idx, 4'(i)}));
      end
    end else if (c == 3'd6) begin
      for (int l = 0; l < 4; l++)
        if (m_dirty[l])
          for (int i = 0; i < 16; i++) exp_q.push_back(28'({m_tag[l], 2'(l), 4'(i)}));
    end

    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd = c; cmd_addr = a; cmd_col = col; wdata_rbr = wd; wdata_cbc = wc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 3'($urandom); cmd_addr = 16'($urandom);
    cyc = 1; fill_beats = 0; last_rd_addr = '0;
    fill_gap = $urandom_range(0, 2);
    wb_gap   = $urandom_range(0, 3);
    while (cyc < 1000) begin
      ddr_rd_valid = 1'b0;
      ddr_wr_ack   = 1'b0;
      ddr_rd_data  = 16'($urandom);
      if (rsp_valid) break;
      if (ddr_wr_req) begin
        if (exp_q.size() == 0) begin
          fail_now("wb_unexpected");
          ddr_wr_ack = 1'b1;
        end else begin
          ea = exp_q[0];
          chk("wb_addr", ddr_wr_addr, 32'(ea));
          chk("wb_data", 32'(ddr_wr_data), 32'(gold[ea[7:0]]));
          if (wb_gap == 0) begin
            ddr_wr_ack = 1'b1;
            ddr[ea[7:0]] = ddr_wr_data;
            wb_addr_log.push_back(ddr_wr_addr);
            wb_data_log.push_back(ddr_wr_data);
            void'(exp_q.pop_front());
            wb_gap = $urandom_range(0, 3);
          end else wb_gap--;
        end
      end else if (ddr_rd_req) begin
        last_rd_addr = ddr_rd_addr;
        if (!exp_fill && !bad_fill) begin
          fail_now("fill_unexpected");
          bad_fill = 1;
        end
        chk("fill_addr", ddr_rd_addr, 32'(fill_base));
        if (fill_gap == 0 && fill_beats < 16) begin
          ddr_rd_valid = 1'b1;
          ddr_rd_data  = ddr[{a[7:4], 4'(fill_beats)}];
          fill_beats++;
          fill_gap = $urandom_range(0, 2);
        end else if (fill_gap > 0) fill_gap--;
      end else begin
        ddr_rd_valid = ($urandom_range(0, 7) == 0);
        ddr_wr_ack   = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    ddr_rd_valid = 1'b0;
    ddr_wr_ack   = 1'b0;
    if (!rsp_valid) begin
      fail_now("rsp_timeout");
      abort = 1;
      return;
    end

    if (c == 3'd1) m_rr = gold[a[7:0]];
    if (c == 3'd3)
      for (int j = 0; j < 16; j++) begin
        w = gold[{a[7:4], 4'(j)}];
        m_rc[j] = w[col];
      end
    chk("rdata_rbr", 32'(rdata_rbr), 32'(m_rr));
    chk("rdata_cbc", 32'(rdata_cbc), 32'(m_rc));
    if (hit || (!is_mem && c != 3'd6)) chk("one_cycle_latency", 32'(cyc), 32'd1);
    chk("wb_beats_missing", 32'(exp_q.size()), 32'd0);
    chk("fill_beats", 32'(fill_beats), exp_fill ? 32'd16 : 32'd0);

    if (c == 3'd2) gold[a[7:0]] = wd;
    if (c == 3'd4)
      for (int j = 0; j < 16; j++) begin
        w = gold[{a[7:4], 4'(j)}];
        w[col] = wc[j];
        gold[{a[7:4], 4'(j)}] = w;
      end
    if (is_mem) begin
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_dirty[idx] = 1'b0;
      end
      if (is_st) m_dirty[idx] = 1'b1;
    end
    if (c == 3'd6) for (int l = 0; l < 4; l++) m_dirty[l] = 1'b0;
    last_cyc = cyc;
    last_fill_beats = fill_beats;

    @(negedge clk);
    chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] a6;
    logic [2:0]  rc;
    int          beats, guard, r;
    rst = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_addr = '0; cmd_col = '0;
    wdata_rbr = '0; wdata_cbc = '0; ddr_rd_valid = 1'b0; ddr_rd_data = '0; ddr_wr_ack = 1'b0;
    for (int a = 0; a < 256; a++)
      ddr[a] = (a < 32) ? 16'(16'hA000 + (a % 16)) : 16'(a * 16'h3B1 + 5);
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rd_req", 32'(ddr_rd_req), 32'd0);
    chk("reset_wr_req", 32'(ddr_wr_req), 32'd0);
    chk("reset_rdata_rbr", 32'(rdata_rbr), 32'd0);
    rst = 1'b1;

    // Cold miss, then a hit in the same line.
    run_cmd(3'd1, 16'h0013, 4'd0, 16'h0, 16'h0);
    chk("t1_fill_addr", last_rd_addr, 32'h10);
    chk("t1_rdata", 32'(rdata_rbr), 32'hA003);
    chk("t1_no_wb", 32'(wb_data_log.size()), 32'd0);
    run_cmd(3'd1, 16'h0015, 4'd0, 16'h0, 16'h0);
    chk("t2_latency", 32'(last_cyc), 32'd1);
    chk("t2_rdata", 32'(rdata_rbr), 32'hA005);
    chk("t2_no_fill", 32'(last_fill_beats), 32'd0);

    // Dirty eviction of the line at 0x10.
    run_cmd(3'd2, 16'h0013, 4'd0, 16'h1234, 16'h0);
    run_cmd(3'd1, 16'h0053, 4'd0, 16'h0, 16'h0);
    chk("t3_wb_count", 32'(wb_data_log.size()), 32'd16);
    if (wb_data_log.size() == 16) begin
      chk("t3_wb_first_addr", wb_addr_log[0], 32'h10);
      chk("t3_wb_beat3", 32'(wb_data_log[3]), 32'h1234);
    end
    chk("t3_fill_addr", last_rd_addr, 32'h50);

    // Column access on line 0 (words 0xA000+i).
    run_cmd(3'd3, 16'h0000, 4'd0, 16'h0, 16'h0);
    chk("t4_cbc_ld", 32'(rdata_cbc), 32'hAAAA);
    run_cmd(3'd4, 16'h0000, 4'd15, 16'h0, 16'h0000);
    run_cmd(3'd1, 16'h0000, 4'd0, 16'h0, 16'h0);
    chk("t4_rbr_after_cbc_st", 32'(rdata_rbr), 32'h2000);

    // Flush with lines 0 and 2 dirty.
    run_cmd(3'd2, 16'h0020, 4'd0, 16'h5555, 16'h0);
    run_cmd(3'd6, 16'h0000, 4'd0, 16'h0, 16'h0);
    chk("t5_flush_beats", 32'(wb_data_log.size()), 32'd32);
    if (wb_addr_log.size() == 32) chk("t5_second_line", wb_addr_log[16], 32'h20);
    run_cmd(3'd1, 16'h0001, 4'd0, 16'h0, 16'h0);
    chk("t5_hit_after_flush", 32'(last_cyc), 32'd1);
    chk("t5_rdata", 32'(rdata_rbr), 32'h2001);

    // Randomized traffic with ack/fill gaps and spurious DDR strobes.
    for (int n = 0; n < 250 && !abort; n++) begin
      r = $urandom_range(0, 15);
      if (r < 4)       rc = 3'd1;
      else if (r < 8)  rc = 3'd2;
      else if (r < 10) rc = 3'd3;
      else if (r < 12) rc = 3'd4;
      else if (r == 12) rc = 3'd6;
      else if (r == 13) rc = 3'd0;
      else if (r == 14) rc = 3'd5;
      else             rc = 3'd7;
      run_cmd(rc, 16'($urandom_range(0, 255)), 4'($urandom), 16'($urandom), 16'($urandom));
    end
    run_cmd(3'd6, 16'h0000, 4'd0, 16'h0, 16'h0);

    // Reset in the middle of a line fill.
    if (!abort) begin
      a6 = (m_valid[1] && m_tag[1] == 10'd2) ? 16'h0013 : 16'h0093;
      @(negedge clk);
      cmd_valid = 1'b1; cmd = 3'd1; cmd_addr = a6;
      @(negedge clk);
      cmd_valid = 1'b0;
      beats = 0;
      guard = 0;
      while (beats < 7 && guard < 200) begin
        ddr_rd_valid = 1'b0;
        if (ddr_rd_req) begin
          ddr_rd_valid = 1'b1;
          ddr_rd_data  = ddr[{a6[7:4], 4'(beats)}];
          beats++;
        end
        @(negedge clk);
        guard++;
      end
      chk("t6_beats_before_reset", 32'(beats), 32'd7);
      chk("t6_still_filling", 32'(ddr_rd_req), 32'd1);
      rst = 1'b0;
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = ddr[{a6[7:4], 4'd7}];
      #1;
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_rd_req", 32'(ddr_rd_req), 32'd0);
      chk("t6_rd_addr", ddr_rd_addr, 32'd0);
      chk("t6_wr_req", 32'(ddr_wr_req), 32'd0);
      chk("t6_rdata_rbr", 32'(rdata_rbr), 32'd0);
      chk("t6_rdata_cbc", 32'(rdata_cbc), 32'd0);
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      run_cmd(3'd1, a6, 4'd0, 16'h0, 16'h0);
      chk("t6_refill_beats", 32'(last_fill_beats), 32'd16);
      chk("t6_refill_addr", last_rd_addr, 32'({a6[15:4], 4'h0}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
